// File: rtl/sync_bus_filter.sv
`default_nettype none
// ============================================================================
// sync_bus_filter : multi-bit async-level synchroniser with per-bit glitch
//                   filter and registered rise/fall/change event pulses.
// Revision: 1.0
// ============================================================================
module sync_bus_filter #(
  parameter int               WIDTH  = 1,
  parameter int               STAGES = 3,
  parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}},
  parameter int               FILTER = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             change
);

  localparam int c_cnt_w = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER - 1);

  if ((STAGES < 2) || (STAGES > 8)) begin : g_bad_stages
    $error("sync_bus_filter: STAGES must be within 2..8");
  end
  if ((FILTER < 1) || (FILTER > 65535)) begin : g_bad_filter
    $error("sync_bus_filter: FILTER must be within 1..65535");
  end

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [WIDTH-1:0] r_chain [STAGES];
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_next_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_change;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_chain[k] <= INIT;
      end
    end else begin
      r_chain[0] <= data_in;
      for (int k = 1; k < STAGES; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
    end
  end

  assign w_sync = r_chain[STAGES-1];

  // Each bit must disagree with data_out for FILTER consecutive cycles
  // before it is accepted; any agreement in between restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_bit_nxt;

    always_comb begin
      w_cnt_nxt = '0;
      w_bit_nxt = r_out[i];
      if (w_sync[i] != r_out[i]) begin
        if (r_cnt == c_cnt_max) begin
          w_bit_nxt = w_sync[i];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end

    assign w_next_out[i] = w_bit_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= INIT;
      r_rise   <= '0;
      r_fall   <= '0;
      r_change <= 1'b0;
    end else begin
      r_out    <= w_next_out;
      r_rise   <= w_next_out & ~r_out;
      r_fall   <= ~w_next_out & r_out;
      r_change <= |(w_next_out ^ r_out);
    end
  end

  assign data_out = r_out;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign change   = r_change;

endmodule
`default_nettype wire

// File: tb/tb_sync_bus_filter.sv
`default_nettype none
// ============================================================================
// tb_sync_bus_filter : directed and randomised self-checking bench for
//                      sync_bus_filter across three parameter sets.
// Revision: 1.0
// ============================================================================
module tb_sync_bus_filter;

  localparam logic [3:0] c_init2 = 4'b1010;
  localparam int         c_s2    = 3;
  localparam int         c_f2    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d0, d1;
  logic [3:0] d2;
  logic       out0, rise0, fall0, ch0;
  logic       out1, rise1, fall1, ch1;
  logic [3:0] out2, rise2, fall2;
  logic       ch2;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state for the 4-bit instance
  logic [3:0] m_hist[$];
  logic [3:0] m_s[$];
  logic [3:0] m_out, m_rise, m_fall;
  logic       m_change;

  always #5 clk = ~clk;

  sync_bus_filter #(.WIDTH(1), .STAGES(3), .INIT(1'b0), .FILTER(1)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(d0), .data_out(out0),
    .rise(rise0), .fall(fall0), .change(ch0));

  sync_bus_filter #(.WIDTH(1), .STAGES(2), .INIT(1'b0), .FILTER(4)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(d1), .data_out(out1),
    .rise(rise1), .fall(fall1), .change(ch1));

  sync_bus_filter #(.WIDTH(4), .STAGES(c_s2), .INIT(c_init2), .FILTER(c_f2)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(d2), .data_out(out2),
    .rise(rise2), .fall(fall2), .change(ch2));

  // Returns at a falling edge with reset released; next rising edge is edge 1.
  task automatic do_reset(input logic [3:0] d2v);
    @(negedge clk);
    rst_n = 1'b0;
    d0 = 1'b0;
    d1 = 1'b0;
    d2 = d2v;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void model_reset();
    m_hist.delete();
    m_s.delete();
    repeat (c_s2 - 1) m_hist.push_back(c_init2);
    repeat (c_f2) m_s.push_back(c_init2);
    m_out    = c_init2;
    m_rise   = '0;
    m_fall   = '0;
    m_change = 1'b0;
  endfunction

  // data_out flips a bit once the synchronised value has differed from it
  // over the last FILTER cycles; the synchronised value is the input sampled
  // STAGES-1 edges earlier.
  function automatic void model_step(input logic [3:0] din);
    logic [3:0] prev, nxt;
    prev = m_out;
    nxt  = m_out;
    for (int b = 0; b < 4; b++) begin
      bit all_diff = 1'b1;
      for (int j = 0; j < c_f2; j++) begin
        if (m_s[m_s.size() - 1 - j][b] == prev[b]) all_diff = 1'b0;
      end
      if (all_diff) nxt[b] = ~prev[b];
    end
    m_rise   = nxt & ~prev;
    m_fall   = ~nxt & prev;
    m_change = (nxt != prev);
    m_out    = nxt;
    m_hist.push_back(din);
    m_s.push_back(m_hist[m_hist.size() - c_s2]);
    if (m_hist.size() > 16) void'(m_hist.pop_front());
    if (m_s.size() > 16) void'(m_s.pop_front());
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    d0 = 1'b1;
    d1 = 1'b1;
    d2 = 4'b0101;
    #1;
    n_total++;
    if ({out0, rise0, fall0, ch0} !== 4'b0000) $display("FAIL reset_u0: got %b expected 0000", {out0, rise0, fall0, ch0});
    else n_pass++;
    n_total++;
    if ({out1, rise1, fall1, ch1} !== 4'b0000) $display("FAIL reset_u1: got %b expected 0000", {out1, rise1, fall1, ch1});
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({out2, rise2, fall2, ch2} !== {c_init2, 9'b0}) $display("FAIL reset_u2: got %b expected %b", {out2, rise2, fall2, ch2}, {c_init2, 9'b0});
    else n_pass++;
  endtask

  task automatic test_latency();
    do_reset(c_init2);
    d0 = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      logic [3:0] exp_v;
      @(posedge clk);
      #1;
      exp_v = {(e >= 4), (e == 4), 1'b0, (e == 4)};
      n_total++;
      if ({out0, rise0, fall0, ch0} !== exp_v) $display("FAIL latency e=%0d: got %b expected %b", e, {out0, rise0, fall0, ch0}, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_filter();
    do_reset(c_init2);
    d1 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      n_total++;
      if ({out1, rise1, fall1, ch1} !== 4'b0000) $display("FAIL glitch e=%0d: got %b expected 0000", e, {out1, rise1, fall1, ch1});
      else n_pass++;
      @(negedge clk);
      if (e == 3) d1 = 1'b0;
    end
    d1 = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      logic [3:0] exp_v;
      @(posedge clk);
      #1;
      exp_v = {(e >= 6), (e == 6), 1'b0, (e == 6)};
      n_total++;
      if ({out1, rise1, fall1, ch1} !== exp_v) $display("FAIL filter_pass e=%0d: got %b expected %b", e, {out1, rise1, fall1, ch1}, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_multibit();
    do_reset(c_init2);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      n_total++;
      if ({out2, rise2, fall2, ch2} !== {c_init2, 9'b0}) $display("FAIL multi_idle e=%0d: got %b expected %b", e, {out2, rise2, fall2, ch2}, {c_init2, 9'b0});
      else n_pass++;
    end
    @(negedge clk);
    d2 = 4'b0101;
    for (int e = 1; e <= 7; e++) begin
      logic [12:0] exp_v;
      @(posedge clk);
      #1;
      exp_v = (e == 5) ? {4'b0101, 4'b0101, 4'b1010, 1'b1}
                       : {((e > 5) ? 4'b0101 : 4'b1010), 9'b0};
      n_total++;
      if ({out2, rise2, fall2, ch2} !== exp_v) $display("FAIL multi_step e=%0d: got %b expected %b", e, {out2, rise2, fall2, ch2}, exp_v);
      else n_pass++;
    end
  endtask

  // Continues from data_out=0101 left by test_multibit.
  task automatic test_reset_mid();
    @(negedge clk);
    d2 = 4'b0011;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      n_total++;
      if ({out2, rise2, fall2, ch2} !== {4'b0101, 9'b0}) $display("FAIL pre_mid e=%0d: got %b expected %b", e, {out2, rise2, fall2, ch2}, {4'b0101, 9'b0});
      else n_pass++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out2, rise2, fall2, ch2} !== {c_init2, 9'b0}) $display("FAIL mid_reset: got %b expected %b", {out2, rise2, fall2, ch2}, {c_init2, 9'b0});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      logic [12:0] exp_v;
      @(posedge clk);
      #1;
      exp_v = (e == 5) ? {4'b0011, 4'b0001, 4'b1000, 1'b1}
                       : {((e > 5) ? 4'b0011 : c_init2), 9'b0};
      n_total++;
      if ({out2, rise2, fall2, ch2} !== exp_v) $display("FAIL post_mid e=%0d: got %b expected %b", e, {out2, rise2, fall2, ch2}, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int hold[4];
    do_reset(4'($urandom));
    model_reset();
    for (int b = 0; b < 4; b++) hold[b] = int'($urandom_range(1, 9));
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk);
      model_step(d2);
      #1;
      n_total++;
      if ({out2, rise2, fall2, ch2} !== {m_out, m_rise, m_fall, m_change})
        $display("FAIL random cyc=%0d: got %b expected %b", cyc, {out2, rise2, fall2, ch2}, {m_out, m_rise, m_fall, m_change});
      else n_pass++;
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          d2[b]   = ~d2[b];
          hold[b] = int'($urandom_range(1, 9));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d0 = 1'b0;
    d1 = 1'b0;
    d2 = c_init2;
    test_reset();
    test_latency();
    test_filter();
    test_multibit();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
